clk_period_meter: RTL and testbench

//  Measures the period of a divided clock (e.g. Clk_CPU from the divider) in cycles of the fast

---
 rtl/clk_period_meter.sv | 91 +++++++++
 tb/tb_clk_period_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period of a slow, asynchronous clock in cycles of clk.
// meas_clk is only sampled through a synchronizer; it never clocks logic.
module clk_period_meter #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 2**26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             meas_clk,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic             timeout_err
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt;
   logic [TW-1:0]    tcnt;
   logic             rise;
   logic             tmo;

   assign rise = s2 & ~s3;
   assign tmo  = (tcnt == TW'(TIMEOUT - 1));
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         cnt         <= '0;
         tcnt        <= '0;
         done        <= 1'b0;
         period      <= '0;
         timeout_err <= 1'b0;
      end else begin
         s1   <= meas_clk;
         s2   <= s1;
         s3   <= s2;
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= ARM;
                  timeout_err <= 1'b0;
                  tcnt        <= '0;
               end
            end
            ARM: begin
               tcnt <= tcnt + 1'b1;
               // a first edge here does not complete a run, so timeout wins
               if (tmo) begin
                  state       <= IDLE;
                  done        <= 1'b1;
                  timeout_err <= 1'b1;
               end else if (rise) begin
                  state <= MEASURE;
                  cnt   <= CNT_W'(1);
               end
            end
            MEASURE: begin
               tcnt <= tcnt + 1'b1;
               if (rise) begin
                  period <= cnt;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else if (tmo) begin
                  state       <= IDLE;
                  done        <= 1'b1;
                  timeout_err <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: three instances cover the
// wide counter, a short timeout and an 8-bit saturating counter.
module tb_clk_period_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        meas  [3];
   logic        start [3];
   logic        busy  [3];
   logic        done  [3];
   logic        terr  [3];
   logic [31:0] per_a;
   logic [7:0]  per_b;
   logic [7:0]  per_c;
   int          mper  [3] = '{0, 0, 0};

   int errors = 0;
   int checks = 0;

   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] q2[$];

   always #5 clk = ~clk;

   clk_period_meter #(.CNT_W(32), .TIMEOUT(100000)) dut_a (
      .clk(clk), .rst(rst), .meas_clk(meas[0]), .start(start[0]),
      .busy(busy[0]), .done(done[0]), .period(per_a),
      .timeout_err(terr[0]));

   clk_period_meter #(.CNT_W(8), .TIMEOUT(100)) dut_b (
      .clk(clk), .rst(rst), .meas_clk(meas[1]), .start(start[1]),
      .busy(busy[1]), .done(done[1]), .period(per_b),
      .timeout_err(terr[1]));

   clk_period_meter #(.CNT_W(8), .TIMEOUT(1000)) dut_c (
      .clk(clk), .rst(rst), .meas_clk(meas[2]), .start(start[2]),
      .busy(busy[2]), .done(done[2]), .period(per_c),
      .timeout_err(terr[2]));

   function automatic logic [31:0] per_of(int i);
      case (i)
         0:       return per_a;
         1:       return {24'd0, per_b};
         default: return {24'd0, per_c};
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(int i, logic [32:0] e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic mon(int i);
      logic [32:0] e;
      logic        have;
      have = 1'b0;
      e    = '0;
      case (i)
         0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
         1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
         default:
            if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL dut%0d unexpected done: got done=1, expected none", i);
      end else begin
         check($sformatf("dut%0d period", i), 64'(per_of(i)), 64'(e[31:0]));
         check($sformatf("dut%0d timeout_err", i), 64'(terr[i]), 64'(e[32]));
         check($sformatf("dut%0d busy at done", i), 64'(busy[i]), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         if (done[i] === 1'b1) mon(i);
   end

   // meas_clk generators: period mper[i] clk cycles, restart aligned on change
   initial begin
      int ph [3];
      int last [3];
      for (int i = 0; i < 3; i++) begin
         meas[i] = 1'b0;
         ph[i]   = 0;
         last[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (mper[i] != last[i]) begin
               last[i] = mper[i];
               ph[i]   = 0;
            end else if (mper[i] > 0) begin
               ph[i] = (ph[i] + 1) % mper[i];
            end
            meas[i] = (mper[i] > 0) && (ph[i] < mper[i] / 2);
         end
      end
   end

   task automatic wait_done(int i, int budget, output int cyc,
                            output logic drop);
      cyc  = 0;
      drop = 1'b0;
      while (done[i] !== 1'b1 && cyc < budget) begin
         if (busy[i] !== 1'b1) drop = 1'b1;
         @(negedge clk);
         cyc++;
      end
      if (done[i] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL dut%0d done wait: got no done, expected within %0d",
                  i, budget);
      end
   endtask

   task automatic run(int i, int p, logic [32:0] e, int budget,
                      output int cyc, output logic drop);
      mper[i] = 0;
      repeat (4) @(negedge clk);
      push(i, e);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      mper[i]  = p;
      wait_done(i, budget, cyc, drop);
      @(negedge clk);
   endtask

   initial begin
      int   cyc;
      logic drop;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy[0]), 64'd0);
      check("reset done", 64'(done[0]), 64'd0);
      check("reset period", 64'(per_a), 64'd0);
      check("reset timeout_err", 64'(terr[0]), 64'd0);
      check("reset busy b", 64'(busy[1]), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 8, {1'b0, 32'd8}, 40, cyc, drop);
      check("clk/8 latency<=20", 64'(cyc <= 20), 64'd1);
      run(0, 2, {1'b0, 32'd2}, 40, cyc, drop);
      run(0, 13, {1'b0, 32'd13}, 60, cyc, drop);

      run(0, 65536, {1'b0, 32'd65536}, 70000, cyc, drop);
      check("clk/65536 busy held", 64'(drop), 64'd0);

      run(1, 8, {1'b0, 32'd8}, 60, cyc, drop);
      run(1, 0, {1'b1, 32'd8}, 200, cyc, drop);
      check("timeout cycles", 64'(cyc), 64'd100);
      check("timeout busy held", 64'(drop), 64'd0);

      run(2, 300, {1'b0, 32'd255}, 1100, cyc, drop);
      run(2, 254, {1'b0, 32'd254}, 1100, cyc, drop);

      // start while busy is ignored; start in the done cycle is accepted
      mper[0] = 0;
      repeat (4) @(negedge clk);
      push(0, {1'b0, 32'd8});
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      mper[0]  = 8;
      repeat (5) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 60, cyc, drop);
      push(0, {1'b0, 32'd8});
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      check("restart from done busy", 64'(busy[0]), 64'd1);
      wait_done(0, 60, cyc, drop);
      repeat (20) @(negedge clk);

      // reset mid-measurement
      mper[0] = 0;
      repeat (4) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      mper[0]  = 20;
      repeat (10) @(negedge clk);
      check("busy before rst", 64'(busy[0]), 64'd1);
      rst = 1'b1;
      #1;
      check("rst busy", 64'(busy[0]), 64'd0);
      check("rst period", 64'(per_a), 64'd0);
      check("rst done", 64'(done[0]), 64'd0);
      check("rst timeout_err b", 64'(terr[1]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run(0, 8, {1'b0, 32'd8}, 40, cyc, drop);
      repeat (4) @(negedge clk);

      check("scoreboard a drained", 64'(q0.size()), 64'd0);
      check("scoreboard b drained", 64'(q1.size()), 64'd0);
      check("scoreboard c drained", 64'(q2.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
